mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Multi-cycle shift-add multiplier controller that reuses the shared 32-bit integer ALU for its adds, so no dedicated multiplier array is needed. It drives the ALU control/operand lines while it owns the ALU and accumulates the partial products. It produces the low 32 bits of the product, which is identical for signed and unsigned operands and serves RV32M MUL. It sits beside the execute stage; the core's ALU input mux selects this block whenever alu_req is high.

Parameters:
D_WIDTH, 32, operand/result width; shift and count logic sized from it (counter width = $clog2(D_WIDTH)+1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
op_a  input  D_WIDTH  multiplicand, sampled on accepted start
op_b  input  D_WIDTH  multiplier, sampled on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
result  output  D_WIDTH  low D_WIDTH bits of op_a*op_b; held from done until next accepted start
alu_req  output  1  high in RUN; core steers ALU inputs from this block
alu_ctrl  output  4  ALU operation; always ALU_ADD (4'b0000)
alu_src_a  output  D_WIDTH  ALU operand A = accumulator in RUN, else 0
alu_src_b  output  D_WIDTH  ALU operand B = shifted multiplicand in RUN, else 0
alu_result  input  D_WIDTH  combinational ALU sum, same cycle

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE; acc, mcand, mplier, count=0; busy=0, done=0, alu_req=0, result=0.
- Internal registers: acc (result source, result=acc), mcand, mplier, count.
- IDLE: on start -> acc<=0, mcand<=op_a, mplier<=op_b, count<=0; next=RUN. Early-exit case: op_b==0 goes straight to DONE.
- RUN, one multiplier bit per cycle:
  - If mplier[0], acc<=alu_result (= acc+mcand, mod 2^D_WIDTH).
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Exit when count==D_WIDTH-1 -> DONE. Early-exit case: also exit when mplier>>1==0.
- DONE: done=1 for exactly one cycle; next=IDLE. start is ignored here and in RUN, never queued.
- Overflow above bit D_WIDTH-1 is discarded (wrap-around). alu_result is ignored outside RUN.
- Latency, start sampled at edge 0:
  - Fixed mode: RUN 32 cycles, done at cycle 33.
  - Early exit: done at cycle (index of highest set bit of op_b)+2; op_b==0 -> cycle 1.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done. No back-to-back overlap.
- Outputs alu_src_a/alu_src_b/alu_ctrl are combinational from state and registers. No other output is combinational from inputs.

Optional Feature:
MUL_EARLY_EXIT_EN:
- Defined: RUN terminates once the remaining multiplier bits are zero; op_b==0 skips RUN.
- Undefined: always exactly D_WIDTH RUN cycles regardless of operands, giving constant latency.
- Result values are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op encodings (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND), used by this block and the decoder.
  - mul_state_t enum {IDLE, RUN, DONE}.
- No sub-module; the counter and shift registers stay inline. The bench instantiates the real ALU wired to alu_* ports.

Test Plan:
- op_a=7, op_b=6, start one cycle:
  - Fixed mode: result=42, done at cycle 33.
  - Early exit: done at cycle 4, alu_req high for 3 cycles.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001 in both modes, done at cycle 33.
- op_a=0xFFFFFFFD (-3), op_b=5 -> result=0xFFFFFFF1 (-15). Early exit: done at cycle 4.
- op_b=0, op_a=0x1234 -> result=0. Fixed mode: done at cycle 33. Early exit: done at cycle 1, alu_req never high.
- Assert rst mid-RUN (cycle 10 of 0x10000*0x10000):
  - Immediately busy=0, done=0, result=0, alu_req=0.
  - A new start of 3*4 after release returns 12.
- start pulsed during RUN and DONE with different operands -> ignored; original result returned, exactly one done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and multiplier sequencer state type
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational integer ALU used by execute and the multiplier sequencer
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_ctrl,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result
);

  localparam int SW = $clog2(W);

  logic [SW-1:0] w_shamt;
  assign w_shamt = i_b[SW-1:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(W-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-add multiplier borrowing the shared ALU for its adds
// Define MUL_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] op_a,
  input  logic [D_WIDTH-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] result,
  output logic               alu_req,
  output logic [3:0]         alu_ctrl,
  output logic [D_WIDTH-1:0] alu_src_a,
  output logic [D_WIDTH-1:0] alu_src_b,
  input  logic [D_WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(D_WIDTH) + 1;

  mul_state_t         r_state;
  mul_state_t         w_next_state;
  logic [D_WIDTH-1:0] r_acc;
  logic [D_WIDTH-1:0] r_mcand;
  logic [D_WIDTH-1:0] r_mplier;
  logic [CW-1:0]      r_count;
  logic               w_last;
  logic               w_skip_run;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last     = (r_count == CW'(D_WIDTH - 1)) || ((r_mplier >> 1) == '0);
  assign w_skip_run = (op_b == '0);
`else
  assign w_last     = (r_count == CW'(D_WIDTH - 1));
  assign w_skip_run = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = w_skip_run ? DONE : RUN;
      RUN:  if (w_last) w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: one multiplier bit per RUN cycle; the add itself happens in the shared ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_count  <= '0;
          end
        end
        RUN: begin
          if (r_mplier[0]) r_acc <= alu_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign alu_req   = (r_state == RUN);
  assign result    = r_acc;
  assign alu_ctrl  = ALU_ADD;
  assign alu_src_a = alu_req ? r_acc : '0;
  assign alu_src_b = alu_req ? r_mcand : '0;

endmodule
